// File: rtl/mitll_merget_sync_if.sv
// mitll_merget_sync_if
// Bundles the pulse inputs and status outputs of the pulse merger.
//   in1, in2     : pulse inputs (one pulse per high cycle)
//   out          : merged, registered pulse output
//   collision    : registered flag, both inputs high in the previous cycle
//   busy         : pending pulse count is non-zero
//   overflow     : sticky dropped-pulse flag
//   dropped_cnt  : saturating count of dropped pulses (CNT_W bits)
// Modports: master drives the inputs (stimulus side), slave is the merger.
interface mitll_merget_sync_if #(
    parameter int CNT_W = 8
);
    logic             in1;
    logic             in2;
    logic             out;
    logic             collision;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] dropped_cnt;

    modport master (
        output in1, in2,
        input  out, collision, busy, overflow, dropped_cnt
    );

    modport slave (
        input  in1, in2,
        output out, collision, busy, overflow, dropped_cnt
    );
endinterface

// File: rtl/mitll_merget_sync.sv
// mitll_merget_sync
// Clocked pulse merger: combines two single-cycle pulse streams into one.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mitll_merget_sync_if.slave (in1, in2, out, collision, busy,
//           overflow, dropped_cnt)
// Parameters:
//   DEPTH : maximum pending pulses held (1..15)
//   CNT_W : width of the dropped-pulse counter
// Build option:
//   MITLL_MERGE_LOSSLESS_EN defined   -> coincident pulses are queued and
//                                        emitted on later cycles; only
//                                        pulses beyond DEPTH are dropped.
//   MITLL_MERGE_LOSSLESS_EN undefined -> physical merger: coincident pulses
//                                        collapse into one, one pulse dropped.
module mitll_merget_sync #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    mitll_merget_sync_if.slave  bus
);
    localparam int P_W   = 4;                 // holds 0..15
    localparam int T_W   = 5;                 // holds P + 2 arrivals
    localparam int SUM_W = ((CNT_W > T_W) ? CNT_W : T_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [P_W-1:0]   p_reg, p_next;
    logic             out_reg, out_next;
    logic             coll_reg, coll_next;
    logic             ovf_reg, ovf_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [T_W-1:0]   drop_amt;
    logic [SUM_W-1:0] cnt_sum;

`ifdef MITLL_MERGE_LOSSLESS_EN
    localparam logic [T_W-1:0] DEPTH_T = T_W'(DEPTH);
    logic [T_W-1:0] arrivals;
    logic [T_W-1:0] total;
    logic [T_W-1:0] remain;
`endif

    always_comb begin
        p_next    = '0;
        out_next  = 1'b0;
        drop_amt  = '0;
        coll_next = bus.in1 & bus.in2;
`ifdef MITLL_MERGE_LOSSLESS_EN
        arrivals = T_W'(bus.in1) + T_W'(bus.in2);
        total    = T_W'(p_reg) + arrivals;
        remain   = '0;
        if (total != '0) begin
            // One pulse leaves per cycle; the rest stay pending.
            out_next = 1'b1;
            remain   = total - T_W'(1);
        end
        if (remain > DEPTH_T) begin
            p_next   = DEPTH_T[P_W-1:0];
            drop_amt = remain - DEPTH_T;
        end else begin
            p_next = remain[P_W-1:0];
        end
`else
        // Physical merger: a coincident pair yields one pulse, one is lost.
        out_next = bus.in1 | bus.in2;
        drop_amt = T_W'(bus.in1 & bus.in2);
`endif
        // Increment computed at full width first so the counter never wraps.
        cnt_sum = SUM_W'(cnt_reg) + SUM_W'(drop_amt);
        if (cnt_sum > CNT_MAX) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
        ovf_next = ovf_reg | (drop_amt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg    <= '0;
            out_reg  <= 1'b0;
            coll_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            p_reg    <= p_next;
            out_reg  <= out_next;
            coll_reg <= coll_next;
            ovf_reg  <= ovf_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign bus.out         = out_reg;
    assign bus.collision   = coll_reg;
    assign bus.busy        = (p_reg != '0);
    assign bus.overflow    = ovf_reg;
    assign bus.dropped_cnt = cnt_reg;
endmodule

// File: tb/tb_mitll_merget_sync.sv
module tb_mitll_merget_sync;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mitll_merget_sync_if #(.CNT_W(8)) bus_a ();
    mitll_merget_sync_if #(.CNT_W(2)) bus_b ();

    mitll_merget_sync #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );
    mitll_merget_sync #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pend, m_out, m_coll, m_ovf, m_cnt_a, m_cnt_b;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_out = 0; m_coll = 0; m_ovf = 0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    // Pulse accounting from the block's rules: pulses in the system each
    // cycle are pending + arrivals; one goes out, the excess beyond DEPTH
    // is dropped (lossless); or coincidences simply lose one (physical).
    task automatic model_step(input int i1, input int i2);
        int drop;
        int total;
`ifdef MITLL_MERGE_LOSSLESS_EN
        total = m_pend + i1 + i2;
        m_out = (total > 0) ? 1 : 0;
        total = total - m_out;
        drop  = (total > DEPTH) ? total - DEPTH : 0;
        m_pend = total - drop;
`else
        m_out  = (i1 + i2 > 0) ? 1 : 0;
        drop   = (i1 + i2 == 2) ? 1 : 0;
        m_pend = 0;
`endif
        m_coll  = (i1 + i2 == 2) ? 1 : 0;
        if (drop > 0) m_ovf = 1;
        m_cnt_a = (m_cnt_a + drop > 255) ? 255 : m_cnt_a + drop;
        m_cnt_b = (m_cnt_b + drop > 3) ? 3 : m_cnt_b + drop;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".out_a"},  int'(bus_a.out),       m_out);
        check({ctx, ".out_b"},  int'(bus_b.out),       m_out);
        check({ctx, ".coll_a"}, int'(bus_a.collision), m_coll);
        check({ctx, ".coll_b"}, int'(bus_b.collision), m_coll);
        check({ctx, ".busy_a"}, int'(bus_a.busy),      (m_pend != 0) ? 1 : 0);
        check({ctx, ".busy_b"}, int'(bus_b.busy),      (m_pend != 0) ? 1 : 0);
        check({ctx, ".ovf_a"},  int'(bus_a.overflow),  m_ovf);
        check({ctx, ".ovf_b"},  int'(bus_b.overflow),  m_ovf);
        check({ctx, ".cnt_a"},  int'(bus_a.dropped_cnt), m_cnt_a);
        check({ctx, ".cnt_b"},  int'(bus_b.dropped_cnt), m_cnt_b);
    endtask

    task automatic drive(input logic i1, input logic i2);
        bus_a.in1 = i1; bus_a.in2 = i2;
        bus_b.in1 = i1; bus_b.in2 = i2;
    endtask

    // Called at a falling edge: apply inputs, clock once, check at next fall.
    task automatic step(input string ctx, input int i1, input int i2);
        drive(i1[0], i2[0]);
        @(posedge clk);
        model_step(i1, i2);
        @(negedge clk);
        $display("%s in1=%0d in2=%0d out=%0d coll=%0d busy=%0d ovf=%0d cnt=%0d/%0d",
                 ctx, i1, i2, bus_a.out, bus_a.collision, bus_a.busy,
                 bus_a.overflow, bus_a.dropped_cnt, bus_b.dropped_cnt);
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int k = 0; k < n; k++) step(ctx, 0, 0);
    endtask

    initial begin
        drive(1'b0, 1'b0);
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset_hold");
        rst_n = 1'b1;

        // Reset in the middle of a coincident burst
        step("burst", 1, 1);
        drive(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        drive(1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_reset", 0, 0);

        // Isolated pulses
        idle("iso", 3);
        step("iso_in1", 1, 0);
        idle("iso", 3);
        step("iso_in2", 0, 1);
        idle("iso", 3);

        // Single coincidence
        step("coinc", 1, 1);
        idle("coinc_drain", 4);

        // Physical-mode pattern: in1, gap, pair
        step("phys_in1", 1, 0);
        step("phys_gap", 0, 0);
        step("phys_pair", 1, 1);
        idle("phys", 3);

        // Sustained coincidence: saturates pending count and counters
        for (int k = 0; k < 8; k++) step("sat", 1, 1);
        idle("sat_drain", 8);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive(1'($urandom), 1'($urandom));
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("rnd", int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
        idle("final_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
